// File: rtl/fmul_rsq.sv
// Issue/result-queue wrapper around the 2-stage fmul pipeline: tracks fired ops
// through a valid/tag delay line and queues results. Optional macro: FMUL_RSQ_BYPASS_EN.
module fmul_rsq #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_x1,
  input  logic [31:0]             in_x2,
  input  logic [TAG_W-1:0]        in_tag,
  output logic [31:0]             mul_x1,
  output logic [31:0]             mul_x2,
  input  logic [31:0]             mul_y,
  input  logic                    mul_ovf,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_y,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_ovf,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_V = (AW+2)'(DEPTH);

  logic             va_q, vb_q, ovfb_q;
  logic [TAG_W-1:0] taga_q, tagb_q;
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW+1:0]    credit;
  logic             fire, push, pop, empty;

  logic [31:0]      y_mem_q   [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic             ovf_mem_q [DEPTH];

  assign mul_x1 = in_x1;
  assign mul_x2 = in_x2;

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);

  // Credits cover queued entries plus both in-flight stages, so fmul never overruns the FIFO.
  assign credit   = {1'b0, count} + {{(AW+1){1'b0}}, va_q} + {{(AW+1){1'b0}}, vb_q};
  assign in_ready = ~rst & (credit < DEPTH_V);
  assign fire     = in_valid & in_ready;

  always_comb begin
    push      = vb_q;
    pop       = ~empty & out_ready;
    out_valid = ~empty;
    out_y     = y_mem_q[rptr_q[AW-1:0]];
    out_tag   = tag_mem_q[rptr_q[AW-1:0]];
    out_ovf   = ovf_mem_q[rptr_q[AW-1:0]];
`ifdef FMUL_RSQ_BYPASS_EN
    if (empty && vb_q) begin
      out_valid = 1'b1;
      out_y     = mul_y;
      out_tag   = tagb_q;
      out_ovf   = ovfb_q;
      push      = ~out_ready;
    end
`endif
    wptr_d = wptr_q + (AW+1)'(push);
    rptr_d = rptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      va_q   <= 1'b0;
      taga_q <= '0;
      vb_q   <= 1'b0;
      tagb_q <= '0;
      ovfb_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      va_q   <= fire;
      taga_q <= in_tag;
      vb_q   <= va_q;
      tagb_q <= taga_q;
      ovfb_q <= mul_ovf;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        y_mem_q[i]   <= '0;
        tag_mem_q[i] <= '0;
        ovf_mem_q[i] <= 1'b0;
      end
    end else if (push) begin
      y_mem_q[wptr_q[AW-1:0]]   <= mul_y;
      tag_mem_q[wptr_q[AW-1:0]] <= tagb_q;
      ovf_mem_q[wptr_q[AW-1:0]] <= ovfb_q;
    end
  end
endmodule
